// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t        : loader FSM states
//   LEN_BYTES      : number of length bytes at the start of a frame
//   BYTES_PER_WORD : bytes per instruction word
package imem_pkg;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot-time writer for the byte-addressed, big-endian instruction memory.
// Accepts a frame  LEN_HI, LEN_LO, 4*N payload bytes, checksum  over a
// valid/ready byte stream, writes payload byte k to BASE_ADDR + k and checks
// an 8-bit additive checksum over the payload.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : begin a load (honoured in IDLE/DONE/ERR only)
//   in_byte, in_valid : stream byte and its valid
//   in_ready          : loader accepts a byte this cycle (state decode)
//   wr_en/addr/data   : registered one-cycle memory byte-write
//   busy              : load in progress
//   done, error       : load finished / finished with failure (levels)
//   words_loaded      : complete 4-byte words written so far
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam int unsigned MAX_WORDS = MEM_BYTES / BYTES_PER_WORD;
  localparam int unsigned LEN_W     = 8 * LEN_BYTES;
  // Byte counter holds up to 4*N; two extra bits mean it can never wrap.
  localparam int unsigned CNT_W     = LEN_W + 2;

  state_t             state;
  logic [7:0]         len_hi;
  logic [CNT_W-1:0]   byte_cnt;
  logic [CNT_W-1:0]   byte_total;
  logic [7:0]         csum;
  logic [LEN_W-1:0]   len_word;
  logic               xfer;

  // Ready is a pure decode of the state register, independent of in_valid.
  assign in_ready = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                    (state == ST_DATA)   || (state == ST_CSUM);
  assign xfer     = in_valid && in_ready;
  assign len_word = {len_hi, in_byte};

  // Loader FSM with registered write port and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      len_hi       <= '0;
      byte_cnt     <= '0;
      byte_total   <= '0;
      csum         <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state        <= ST_LEN_HI;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            csum         <= '0;
            byte_cnt     <= '0;
          end
        end
        ST_LEN_HI: begin
          if (xfer) begin
            len_hi <= in_byte;
            state  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (xfer) begin
            byte_total <= {len_word, 2'b00};
            if (len_word > LEN_W'(MAX_WORDS)) begin
              state <= ST_ERR;
              busy  <= 1'b0;
              done  <= 1'b1;
              error <= 1'b1;
            end else if (len_word == '0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            wr_en    <= 1'b1;
            wr_addr  <= BASE_ADDR + 32'(byte_cnt);
            wr_data  <= in_byte;
            csum     <= csum + in_byte;
            byte_cnt <= byte_cnt + CNT_W'(1);
            // Last byte of a word completes it; count lands with its wr_en.
            if (byte_cnt[1:0] == 2'd3) begin
              words_loaded <= words_loaded + 16'd1;
            end
            if (byte_cnt + CNT_W'(1) == byte_total) begin
              state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            error <= (in_byte != csum);
            state <= (in_byte == csum) ? ST_DONE : ST_ERR;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the byte-addressed, big-endian instruction memory. It accepts a framed byte stream over a valid/ready handshake and writes each payload byte into consecutive memory addresses starting at a configurable base. It also checks an 8-bit additive checksum and reports done/error status. It sits between the host byte source (UART or testbench) and the instruction memory's write port, and holds the CPU off via `busy` while programming is in progress.

## Interface
- `MEM_BYTES`, 64: instruction memory capacity in bytes; max payload = `MEM_BYTES/4` words.
- `BASE_ADDR`, 32'h0: byte address of the first written byte.
- `clk` input 1: sole clock; all logic updates on posedge.
- `rst_n` input 1: synchronous, active-low reset, sampled on posedge `clk`.
- `start` input 1: begin a load; honoured only in IDLE, DONE or ERR.
- `in_byte` input 8: stream byte.
- `in_valid` input 1: `in_byte` is valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `wr_en` output 1: one-cycle memory byte-write strobe.
- `wr_addr` output 32: byte address for the write.
- `wr_data` output 8: byte to write.
- `busy` output 1: high from start acceptance until DONE or ERR.
- `done` output 1: load finished (success or failure); level signal.
- `error` output 1: length overflow or checksum mismatch; level signal.
- `words_loaded` output 16: count of complete 4-byte words written.

## Operation
- Frame format: `LEN_HI`, `LEN_LO` (16-bit big-endian word count N), then 4·N payload bytes, then 1 checksum byte.
- Payload byte k goes to address `BASE_ADDR + k`. Big-endian: byte 4i holds instruction i bits [31:24], byte 4i+3 holds bits [7:0]. The stream carries bytes already in this order; no reordering.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR with `start`=1: go to LEN_HI; clear `done`, `error`, `words_loaded`, checksum accumulator and byte counter.
- LEN_HI: on handshake, latch the high byte, then go to LEN_LO.
- LEN_LO: on handshake, form N.
  - N > `MEM_BYTES/4`: go to ERR.
  - N = 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA: on each handshake, issue the write, add the byte to the 8-bit accumulator (mod 256), and increment the byte counter. When the counter reaches 4·N, go to CSUM.
- CSUM: on handshake, go to DONE if the byte equals the accumulator, else ERR.
- DONE: `done`=1, `error`=0. ERR: `done`=1, `error`=1. Both hold until the next `start` or reset.
- `start` in LEN_HI…CSUM: ignored.
- The checksum covers payload bytes only, not the length bytes.

## Timing
- Handshake: a transfer occurs on a posedge with `in_valid && in_ready`.
- `in_ready` = 1 exactly in LEN_HI, LEN_LO, DATA and CSUM. It is a combinational decode of the state register and never depends on `in_valid`.
- Write latency: `wr_en`/`wr_addr`/`wr_data` are registered and valid the cycle after the DATA handshake. `wr_en` is a single-cycle pulse per byte; consecutive handshakes give back-to-back pulses.
- `words_loaded` increments in the same cycle as the `wr_en` pulse for the byte at address offset 4i+3.
- `busy` is registered: 1 the cycle after `start` is accepted, 0 the cycle DONE or ERR is entered.
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `error`=0, `words_loaded`=0; state=IDLE.
- Reset mid-load: all of the above return to reset values at the next edge, with no further `wr_en`. Bytes already written remain in memory.
- Stalls: `in_valid` gaps of any length are tolerated; state and counters hold.
- The byte counter is 16+2 bits wide and never wraps, because of the overflow check.

## Structure
- Shared package `imem_pkg`:
  - FSM state typedef
  - `LEN_BYTES`=2
  - `BYTES_PER_WORD`=4
- No sub-module; single flat FSM plus datapath registers.

## Test plan
- Start, stream 00 02 20 08 00 05 01 09 50 20 A7 -> eight `wr_en` pulses writing addr 0..7 = 20,08,00,05,01,09,50,20; `words_loaded`=2; `done`=1, `error`=0, `busy`=0.
- Same frame with checksum A6 -> all eight writes occur; `done`=1, `error`=1.
- Length 00 11 (17 > 16) -> ERR right after LEN_LO with no `wr_en`; `in_ready`=0; `done`=1, `error`=1.
- Length 00 00, checksum 00 -> DONE with no writes; `words_loaded`=0.
- Valid frame with random 0–5 cycle `in_valid` gaps -> identical write sequence and status to the first test; `start` pulsed mid-DATA is ignored.
- `rst_n`=0 after the 5th payload byte -> next cycle all outputs are at reset values and no further writes; a subsequent full frame loads correctly from addr 0.
